// File: rtl/stage_id_hs_pkg.sv
// Shared RV32I decode constants and helpers for the instruction-decode stage.
// Opcode/func3 encodings, immediate selection and the per-opcode decode table.
package stage_id_hs_pkg;

    localparam int REG_AW = 5;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SH
    } imm_sel_e;

    typedef struct packed {
        imm_sel_e imm_sel;
        logic     use_rs1;
        logic     use_rs2;
        logic     legal;
        logic     wreg;
    } decode_t;

    // 32-bit immediate; the caller sign-extends to the datapath width.
    function automatic logic signed [31:0] gen_imm(input imm_sel_e sel, input logic [31:0] inst);
        case (sel)
            IMM_I:   return {{20{inst[31]}}, inst[31:20]};
            IMM_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   return {inst[31:12], 12'h000};
            IMM_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_SH:  return {27'd0, inst[24:20]};
            default: return 32'sd0;
        endcase
    endfunction

    function automatic decode_t decode(input logic [6:0] opcode, input logic [2:0] f3);
        decode_t d;
        d = '{imm_sel: IMM_NONE, use_rs1: 1'b0, use_rs2: 1'b0, legal: 1'b1, wreg: 1'b0};
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                d.imm_sel = IMM_U;
                d.wreg    = 1'b1;
            end
            OP_JAL: begin
                d.imm_sel = IMM_J;
                d.wreg    = 1'b1;
            end
            OP_JALR, OP_LOAD: begin
                d.imm_sel = IMM_I;
                d.use_rs1 = 1'b1;
                d.wreg    = 1'b1;
            end
            OP_BRANCH: begin
                d.imm_sel = IMM_B;
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
            end
            OP_STORE: begin
                d.imm_sel = IMM_S;
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
            end
            OP_IMM: begin
                d.imm_sel = (f3 == F3_SLL || f3 == F3_SR) ? IMM_SH : IMM_I;
                d.use_rs1 = 1'b1;
                d.wreg    = 1'b1;
            end
            OP_REG: begin
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
                d.wreg    = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: begin
                d.imm_sel = IMM_I;
            end
            default: begin
                d.legal = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/stage_id_hs_if.sv
// Upstream (IF/ID) and downstream (ID/EX) handshake bundle of the decode stage.
// A beat transfers on a rising edge where valid && ready; a producer holds valid and payload stable until then.
interface stage_id_hs_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;

    logic            out_valid;
    logic            out_ready;
    logic [6:0]      out_opcode;
    logic [2:0]      out_func3;
    logic [6:0]      out_func7;
    logic [4:0]      out_rd;
    logic            out_wreg;
    logic            out_illegal;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [XLEN-1:0] out_imm;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_opcode, out_func3, out_func7, out_rd,
        input  out_wreg, out_illegal, out_pc, out_op1, out_op2, out_imm
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_opcode, out_func3, out_func7, out_rd,
        output out_wreg, out_illegal, out_pc, out_op1, out_op2, out_imm
    );
endinterface

// File: rtl/stage_id_hs_fwd_mux.sv
// Priority forwarding select for one source register; lowest index wins.
// Also reports whether the winning source is still waiting on its data.
module stage_id_hs_fwd_mux
    import stage_id_hs_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NFWD = 2
) (
    input  logic [REG_AW-1:0]      rs,
    input  logic [XLEN-1:0]        reg_data,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD-1:0]        fwd_pend,
    input  logic [NFWD*REG_AW-1:0] fwd_rd,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    output logic [XLEN-1:0]        data,
    output logic                   pend
);

    always_comb begin
        data = reg_data;
        pend = 1'b0;
        if (rs == '0) begin
            data = '0;
        end else begin
            // Walk from the oldest source so the youngest hit is the last write.
            for (int i = NFWD - 1; i >= 0; i--) begin
                if (fwd_valid[i] && fwd_rd[REG_AW*i +: REG_AW] == rs) begin
                    data = fwd_data[XLEN*i +: XLEN];
                    pend = fwd_pend[i];
                end
            end
        end
    end

endmodule

// File: rtl/stage_id_hs.sv
// Registered RV32I decode stage with operand forwarding, load-use stall,
// in-ID control-transfer resolution and valid/ready handshakes on both sides.
module stage_id_hs
    import stage_id_hs_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NFWD       = 2,
    parameter int RESOLVE_BR = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    stage_id_hs_if.slave           bus,
    output logic [REG_AW-1:0]      rs1_addr_o,
    output logic [REG_AW-1:0]      rs2_addr_o,
    input  logic [XLEN-1:0]        rs1_data_i,
    input  logic [XLEN-1:0]        rs2_data_i,
    input  logic [NFWD-1:0]        fwd_valid_i,
    input  logic [NFWD-1:0]        fwd_pend_i,
    input  logic [NFWD*REG_AW-1:0] fwd_rd_i,
    input  logic [NFWD*XLEN-1:0]   fwd_data_i,
    input  logic                   flush_i,
    output logic                   redirect_o,
    output logic [XLEN-1:0]        redirect_pc_o
);

    logic [31:0]       inst;
    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [REG_AW-1:0] rd;
    decode_t           dec;

    assign inst       = bus.in_inst;
    assign opcode     = inst[6:0];
    assign rd         = inst[11:7];
    assign f3         = inst[14:12];
    assign f7         = inst[31:25];
    assign rs1_addr_o = inst[19:15];
    assign rs2_addr_o = inst[24:20];
    assign dec        = decode(opcode, f3);

    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            rs1_pend, rs2_pend;

    stage_id_hs_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs1 (
        .rs        (inst[19:15]),
        .reg_data  (rs1_data_i),
        .fwd_valid (fwd_valid_i),
        .fwd_pend  (fwd_pend_i),
        .fwd_rd    (fwd_rd_i),
        .fwd_data  (fwd_data_i),
        .data      (rs1_val),
        .pend      (rs1_pend)
    );

    stage_id_hs_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs2 (
        .rs        (inst[24:20]),
        .reg_data  (rs2_data_i),
        .fwd_valid (fwd_valid_i),
        .fwd_pend  (fwd_pend_i),
        .fwd_rd    (fwd_rd_i),
        .fwd_data  (fwd_data_i),
        .data      (rs2_val),
        .pend      (rs2_pend)
    );

    logic [XLEN-1:0] imm, pc_plus4;
    assign imm      = XLEN'(gen_imm(dec.imm_sel, inst));
    assign pc_plus4 = bus.in_pc + XLEN'(4);

    logic br_taken;
    always_comb begin
        br_taken = 1'b0;
        case (f3)
            F3_BEQ:  br_taken = (rs1_val == rs2_val);
            F3_BNE:  br_taken = (rs1_val != rs2_val);
            F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: br_taken = (rs1_val <  rs2_val);
            F3_BGEU: br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    logic            ctrl_redir;
    logic [XLEN-1:0] ctrl_target;
    always_comb begin
        ctrl_redir  = 1'b0;
        ctrl_target = '0;
        case (opcode)
            OP_JAL: begin
                ctrl_redir  = 1'b1;
                ctrl_target = bus.in_pc + imm;
            end
            OP_JALR: begin
                ctrl_redir  = 1'b1;
                ctrl_target = (rs1_val + imm) & ~XLEN'(1);
            end
            OP_BRANCH: begin
                if (RESOLVE_BR != 0 && br_taken) begin
                    ctrl_redir  = 1'b1;
                    ctrl_target = bus.in_pc + imm;
                end
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] op1, op2;
    always_comb begin
        op1 = '0;
        op2 = '0;
        case (opcode)
            OP_LUI:           op1 = imm;
            OP_AUIPC:         op1 = imm + bus.in_pc;
            OP_JAL, OP_JALR:  op1 = pc_plus4;
            OP_IMM: begin
                op1 = rs1_val;
                op2 = imm;
            end
            OP_REG, OP_BRANCH, OP_STORE: begin
                op1 = rs1_val;
                op2 = rs2_val;
            end
            OP_LOAD:          op1 = rs1_val;
            default: ;
        endcase
    end

    logic out_valid_q, redirect_q;
    logic stall, accept, take;

    assign stall = (dec.use_rs1 && rs1_pend) || (dec.use_rs2 && rs2_pend);
    // In the redirect cycle the presented word is wrong-path: always drain it.
    assign bus.in_ready = rdy && (redirect_q || (!stall && (!out_valid_q || bus.out_ready)));
    assign accept = bus.in_valid && bus.in_ready;
    assign take   = accept && !flush_i && !redirect_q && (inst != ZERO_WORD);

    logic [6:0]        opcode_q, f7_q;
    logic [2:0]        f3_q;
    logic [REG_AW-1:0] rd_q;
    logic              wreg_q, illegal_q;
    logic [XLEN-1:0]   pc_q, op1_q, op2_q, imm_q, redirect_pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q   <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            opcode_q      <= '0;
            f3_q          <= '0;
            f7_q          <= '0;
            rd_q          <= '0;
            wreg_q        <= 1'b0;
            illegal_q     <= 1'b0;
            pc_q          <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            imm_q         <= '0;
        end else if (rdy) begin
            if (flush_i) begin
                out_valid_q <= 1'b0;
                redirect_q  <= 1'b0;
            end else begin
                redirect_q <= take && ctrl_redir;
                if (take)
                    out_valid_q <= 1'b1;
                else if (bus.out_ready)
                    out_valid_q <= 1'b0;
            end
            if (take) begin
                opcode_q  <= opcode;
                f3_q      <= f3;
                f7_q      <= f7;
                rd_q      <= rd;
                wreg_q    <= dec.wreg && dec.legal;
                illegal_q <= !dec.legal;
                pc_q      <= bus.in_pc;
                op1_q     <= op1;
                op2_q     <= op2;
                imm_q     <= imm;
            end
            if (take && ctrl_redir)
                redirect_pc_q <= ctrl_target;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_opcode  = opcode_q;
    assign bus.out_func3   = f3_q;
    assign bus.out_func7   = f7_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_wreg    = wreg_q;
    assign bus.out_illegal = illegal_q;
    assign bus.out_pc      = pc_q;
    assign bus.out_op1     = op1_q;
    assign bus.out_op2     = op2_q;
    assign bus.out_imm     = imm_q;
    assign redirect_o      = redirect_q;
    assign redirect_pc_o   = redirect_pc_q;

endmodule

// File: tb/tb_stage_id_hs.sv
// Directed bench for stage_id_hs: a vector table for single-instruction decode
// plus hand-written sequences for stall, squash, back-pressure, flush and reset.
module tb_stage_id_hs;

    localparam logic [6:0] OPI  = 7'b0010011;
    localparam logic [6:0] OPR  = 7'b0110011;
    localparam logic [6:0] OPLD = 7'b0000011;
    localparam logic [6:0] OPJR = 7'b1100111;
    localparam logic [6:0] OPLU = 7'b0110111;
    localparam logic [6:0] OPAU = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [1:0]  fwd_valid, fwd_pend;
    logic [9:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    stage_id_hs_if #(.XLEN(32)) bus ();

    stage_id_hs #(.XLEN(32), .NFWD(2), .RESOLVE_BR(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .bus           (bus),
        .rs1_addr_o    (rs1_addr),
        .rs2_addr_o    (rs2_addr),
        .rs1_data_i    (rs1_data),
        .rs2_data_i    (rs2_data),
        .fwd_valid_i   (fwd_valid),
        .fwd_pend_i    (fwd_pend),
        .fwd_rd_i      (fwd_rd),
        .fwd_data_i    (fwd_data),
        .flush_i       (flush),
        .redirect_o    (redirect),
        .redirect_pc_o (redirect_pc)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] inst, pc, rs1d, rs2d;
        logic [1:0]  fv;
        logic [9:0]  frd;
        logic [63:0] fdata;
        logic [2:0]  mask;  // check {op1, op2, imm}
        logic [31:0] op1, op2, imm;
        logic        wreg, ill, redir;
        logic [31:0] rpc;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
        return {7'd0, rs2, rs1, 3'b000, rd, OPR};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic add(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs1d,
                       input logic [31:0] rs2d, input logic [1:0] fv, input logic [9:0] frd,
                       input logic [63:0] fdata, input logic [2:0] mask, input logic [31:0] op1,
                       input logic [31:0] op2, input logic [31:0] imm, input logic wreg,
                       input logic ill, input logic redir, input logic [31:0] rpc);
        vec_t v;
        v = '{inst, pc, rs1d, rs2d, fv, frd, fdata, mask, op1, op2, imm, wreg, ill, redir, rpc};
        vq.push_back(v);
    endtask

    task automatic clear_fwd();
        fwd_valid = '0;
        fwd_pend  = '0;
        fwd_rd    = '0;
        fwd_data  = '0;
    endtask

    // driver: one instruction with out_ready=1, then an idle cycle
    task automatic apply_vec(input vec_t v);
        logic [31:0] e_op1;
        @(negedge clk);
        bus.in_inst  = v.inst;
        bus.in_pc    = v.pc;
        rs1_data     = v.rs1d;
        rs2_data     = v.rs2d;
        fwd_valid    = v.fv;
        fwd_rd       = v.frd;
        fwd_data     = v.fdata;
        bus.in_valid = 1'b1;
        exp_q.push_back(v.op1);
        #1;
        check("in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rs1_addr", {27'd0, rs1_addr}, {27'd0, v.inst[19:15]});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        e_op1 = exp_q.pop_front();
        check("out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("out_pc", bus.out_pc, v.pc);
        check("out_opcode", {25'd0, bus.out_opcode}, {25'd0, v.inst[6:0]});
        check("out_wreg", {31'd0, bus.out_wreg}, {31'd0, v.wreg});
        check("out_illegal", {31'd0, bus.out_illegal}, {31'd0, v.ill});
        check("redirect", {31'd0, redirect}, {31'd0, v.redir});
        if (v.redir) check("redirect_pc", redirect_pc, v.rpc);
        if (v.mask[2]) check("out_op1", bus.out_op1, e_op1);
        if (v.mask[1]) check("out_op2", bus.out_op2, v.op2);
        if (v.mask[0]) check("out_imm", bus.out_imm, v.imm);
        @(negedge clk);
        @(posedge clk);
        #1;
        check("idle_redirect", {31'd0, redirect}, 32'd0);
        check("idle_valid", {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_inst   = '0;
        bus.out_ready = 1'b1;
        rs1_data = '0;
        rs2_data = '0;
        clear_fwd();

        // reset state
        #1;
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_op1", bus.out_op1, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // inst, pc, rs1d, rs2d, fv, frd, fdata, mask, op1, op2, imm, wreg, ill, redir, rpc
        add(enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI), 32'h100, 32'hdead, 32'h0, 2'b00, 10'd0, 64'd0,
            3'b111, 32'h0, 32'h5, 32'h5, 1, 0, 0, 32'h0);
        add(enc_r(5'd2, 5'd1, 5'd3), 32'h104, 32'h55, 32'h4, 2'b11, {5'd1, 5'd1}, {32'd9, 32'd7},
            3'b110, 32'h7, 32'h4, 32'h0, 1, 0, 0, 32'h0);
        add(enc_r(5'd2, 5'd1, 5'd3), 32'h108, 32'h11, 32'h4, 2'b10, {5'd2, 5'd0}, {32'h99, 32'h0},
            3'b110, 32'h11, 32'h99, 32'h0, 1, 0, 0, 32'h0);
        add(enc_r(5'd2, 5'd0, 5'd3), 32'h10c, 32'h44, 32'h3, 2'b01, {5'd0, 5'd0}, {32'h0, 32'h77},
            3'b110, 32'h0, 32'h3, 32'h0, 1, 0, 0, 32'h0);
        add({20'h12345, 5'd5, OPLU}, 32'h110, 32'h0, 32'h0, 2'b00, 10'd0, 64'd0,
            3'b101, 32'h12345000, 32'h0, 32'h12345000, 1, 0, 0, 32'h0);
        add({20'h00001, 5'd5, OPAU}, 32'h100, 32'h0, 32'h0, 2'b00, 10'd0, 64'd0,
            3'b101, 32'h1100, 32'h0, 32'h1000, 1, 0, 0, 32'h0);
        add(enc_i(12'hfff, 5'd2, 3'b000, 5'd1, OPI), 32'h114, 32'h10, 32'h0, 2'b00, 10'd0, 64'd0,
            3'b111, 32'h10, 32'hffffffff, 32'hffffffff, 1, 0, 0, 32'h0);
        add(enc_i(12'h403, 5'd2, 3'b101, 5'd1, OPI), 32'h118, 32'h80000000, 32'h0, 2'b00, 10'd0, 64'd0,
            3'b111, 32'h80000000, 32'h3, 32'h3, 1, 0, 0, 32'h0);
        add(enc_s(12'd8, 5'd2, 5'd1, 3'b010), 32'h11c, 32'h20, 32'h30, 2'b00, 10'd0, 64'd0,
            3'b111, 32'h20, 32'h30, 32'h8, 0, 0, 0, 32'h0);
        add(enc_i(12'hffc, 5'd1, 3'b010, 5'd4, OPLD), 32'h120, 32'h40, 32'h0, 2'b00, 10'd0, 64'd0,
            3'b101, 32'h40, 32'h0, 32'hfffffffc, 1, 0, 0, 32'h0);
        add(enc_j(21'h20, 5'd1), 32'h100, 32'h0, 32'h0, 2'b00, 10'd0, 64'd0,
            3'b101, 32'h104, 32'h0, 32'h20, 1, 0, 1, 32'h120);
        add(enc_i(12'd3, 5'd2, 3'b000, 5'd1, OPJR), 32'h100, 32'h200, 32'h0, 2'b00, 10'd0, 64'd0,
            3'b101, 32'h104, 32'h0, 32'h3, 1, 0, 1, 32'h202);
        add(enc_b(13'd16, 5'd2, 5'd1, 3'b000), 32'h100, 32'h5, 32'h5, 2'b00, 10'd0, 64'd0,
            3'b111, 32'h5, 32'h5, 32'h10, 0, 0, 1, 32'h110);
        add(enc_b(13'd16, 5'd2, 5'd1, 3'b000), 32'h100, 32'h5, 32'h6, 2'b00, 10'd0, 64'd0,
            3'b111, 32'h5, 32'h6, 32'h10, 0, 0, 0, 32'h0);
        add(enc_b(13'h1ff8, 5'd2, 5'd1, 3'b100), 32'h100, 32'hffffffff, 32'h1, 2'b00, 10'd0, 64'd0,
            3'b001, 32'h0, 32'h0, 32'hfffffff8, 0, 0, 1, 32'hf8);
        add(enc_b(13'h1ff8, 5'd2, 5'd1, 3'b110), 32'h100, 32'hffffffff, 32'h1, 2'b00, 10'd0, 64'd0,
            3'b001, 32'h0, 32'h0, 32'hfffffff8, 0, 0, 0, 32'h0);
        add(enc_b(13'd4, 5'd2, 5'd1, 3'b111), 32'h100, 32'hffffffff, 32'h1, 2'b00, 10'd0, 64'd0,
            3'b001, 32'h0, 32'h0, 32'h4, 0, 0, 1, 32'h104);
        add(32'h0000007f, 32'h130, 32'h0, 32'h0, 2'b00, 10'd0, 64'd0,
            3'b000, 32'h0, 32'h0, 32'h0, 0, 1, 0, 32'h0);

        foreach (vq[k]) apply_vec(vq[k]);
        clear_fwd();

        // load-use stall for two cycles, then release with fresh data
        @(negedge clk);
        fwd_valid = 2'b01;
        fwd_rd    = {5'd0, 5'd5};
        fwd_data  = {32'h0, 32'haa};
        fwd_pend  = 2'b01;
        bus.in_inst  = enc_i(12'd1, 5'd5, 3'b000, 5'd6, OPI);
        bus.in_pc    = 32'h200;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1 check("stall_ready", {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk);
            #1 check("stall_no_out", {31'd0, bus.out_valid}, 32'd0);
            @(negedge clk);
        end
        fwd_pend = 2'b00;
        fwd_data = {32'h0, 32'hbb};
        #1 check("stall_release", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        check("stall_op1", bus.out_op1, 32'hbb);
        check("stall_op2", bus.out_op2, 32'h1);

        // older pending source is shadowed by a ready younger hit
        @(negedge clk);
        fwd_valid = 2'b11;
        fwd_rd    = {5'd5, 5'd5};
        fwd_pend  = 2'b10;
        fwd_data  = {32'hcc, 32'hdd};
        #1 check("prio_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("prio_op1", bus.out_op1, 32'hdd);
        clear_fwd();
        @(negedge clk);

        // taken BEQ squashes the next presented instruction
        @(negedge clk);
        rs1_data = 32'h5;
        rs2_data = 32'h5;
        bus.in_inst  = enc_b(13'd16, 5'd2, 5'd1, 3'b000);
        bus.in_pc    = 32'h100;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("beq_redir", {31'd0, redirect}, 32'd1);
        check("beq_target", redirect_pc, 32'h110);
        @(negedge clk);
        bus.in_inst = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);
        bus.in_pc   = 32'h104;
        #1 check("squash_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("squash_out", {31'd0, bus.out_valid}, 32'd0);
        check("squash_redir", {31'd0, redirect}, 32'd0);

        // JAL under back-pressure; rdy low stretches the redirect pulse
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_inst   = enc_j(21'h20, 5'd1);
        bus.in_pc     = 32'h300;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("jal_redir", {31'd0, redirect}, 32'd1);
        check("jal_target", redirect_pc, 32'h320);
        rdy = 1'b0;
        @(posedge clk);
        #1;
        check("rdy_hold_redir", {31'd0, redirect}, 32'd1);
        check("rdy_low_ready", {31'd0, bus.in_ready}, 32'd0);
        rdy = 1'b1;
        @(posedge clk);
        #1;
        check("redir_one_cycle", {31'd0, redirect}, 32'd0);
        check("held_valid", {31'd0, bus.out_valid}, 32'd1);
        check("held_op1", bus.out_op1, 32'h304);
        bus.in_inst = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);
        #1 check("bp_ready", {31'd0, bus.in_ready}, 32'd0);

        // flush kills the held output, and beats a simultaneous accept
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_held", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        flush = 1'b0;
        check("flush_accept", {31'd0, bus.out_valid}, 32'd0);

        // reset asserted while an output is held and the next word is stalled
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_inst   = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);
        bus.in_pc     = 32'h400;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.in_inst = enc_i(12'd1, 5'd5, 3'b000, 5'd6, OPI);
        fwd_valid = 2'b01;
        fwd_rd    = {5'd0, 5'd5};
        fwd_pend  = 2'b01;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_mid_op2", bus.out_op2, 32'd0);
        check("rst_mid_imm", bus.out_imm, 32'd0);
        check("rst_mid_pc", bus.out_pc, 32'd0);
        check("rst_mid_wreg", {31'd0, bus.out_wreg}, 32'd0);
        check("rst_mid_redir", {31'd0, redirect}, 32'd0);
        bus.in_valid = 1'b0;
        clear_fwd();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
